// File: rtl/keyboard_move_ctl.sv
// keyboard_move_ctl
// Turns PS/2 Set-2 scan-code bytes into held-key movement levels for the
// player control FSM. Tracks make/break (F0) and extended (E0) prefixes,
// keeps one held flag per recognised key and resolves left+right conflicts
// in favour of the most recently pressed direction.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   rx_data    in   [7:0] scan-code byte, qualified by rx_valid
//   rx_valid   in   one-cycle strobe per received byte
//   m_left     out  resolved move-left level (registered)
//   m_right    out  resolved move-right level (registered)
//   key_action out  action key held level (registered)
//   seq_error  out  one-cycle pulse when a prefix times out (registered)
module keyboard_move_ctl #(
  parameter int unsigned PREFIX_TIMEOUT = 1_300_000,
  parameter logic [7:0]  CODE_LEFT_ALT  = 8'h1C,
  parameter logic [7:0]  CODE_RIGHT_ALT = 8'h23,
  parameter logic [7:0]  CODE_ACTION    = 8'h29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       m_left,
  output logic       m_right,
  output logic       key_action,
  output logic       seq_error
);

  localparam int unsigned CNT_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  localparam logic [7:0] CODE_EXT         = 8'hE0;
  localparam logic [7:0] CODE_BRK         = 8'hF0;
  localparam logic [7:0] CODE_LEFT_ARROW  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT_ARROW = 8'h74;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             timeout_s;

  logic arrow_left_r,  arrow_left_s;
  logic arrow_right_r, arrow_right_s;
  logic alt_left_r,    alt_left_s;
  logic alt_right_r,   alt_right_s;
  logic action_r,      action_s;
  logic last_dir_r,    last_dir_s;
  logic seq_error_r,   seq_error_s;

  logic left_held_s, right_held_s;
  logic m_left_r,  m_left_s;
  logic m_right_r, m_right_s;
  logic key_action_r;

  // Prefix timeout: a pending prefix that has waited its full budget with no new byte.
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r != ST_IDLE) && !rx_valid && (cnt_r == CNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Timeout counter next value: only runs while a prefix is pending and quiet.
  always_comb begin
    cnt_s = cnt_r;
    if (rx_valid || (state_r == ST_IDLE) || timeout_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // Scan-code decoder: next state, held flags, last direction and error pulse.
  always_comb begin
    state_s       = state_r;
    arrow_left_s  = arrow_left_r;
    arrow_right_s = arrow_right_r;
    alt_left_s    = alt_left_r;
    alt_right_s   = alt_right_r;
    action_s      = action_r;
    last_dir_s    = last_dir_r;
    seq_error_s   = 1'b0;
    if (rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_data == CODE_EXT) begin
            state_s = ST_EXT;
          end else if (rx_data == CODE_BRK) begin
            state_s = ST_BRK;
          end else if (rx_data == CODE_LEFT_ALT) begin
            alt_left_s = 1'b1;
            last_dir_s = DIR_LEFT;
          end else if (rx_data == CODE_RIGHT_ALT) begin
            alt_right_s = 1'b1;
            last_dir_s  = DIR_RIGHT;
          end else if (rx_data == CODE_ACTION) begin
            action_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (rx_data == CODE_BRK) begin
            state_s = ST_EXT_BRK;
          end else if (rx_data == CODE_LEFT_ARROW) begin
            arrow_left_s = 1'b1;
            last_dir_s   = DIR_LEFT;
            state_s      = ST_IDLE;
          end else if (rx_data == CODE_RIGHT_ARROW) begin
            arrow_right_s = 1'b1;
            last_dir_s    = DIR_RIGHT;
            state_s       = ST_IDLE;
          end else if (rx_data == CODE_EXT) begin
            // repeated E0 keeps the extended prefix alive
            state_s = ST_EXT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (rx_data == CODE_BRK) begin
            state_s = ST_BRK;
          end else if (rx_data == CODE_LEFT_ALT) begin
            alt_left_s = 1'b0;
            state_s    = ST_IDLE;
          end else if (rx_data == CODE_RIGHT_ALT) begin
            alt_right_s = 1'b0;
            state_s     = ST_IDLE;
          end else if (rx_data == CODE_ACTION) begin
            action_s = 1'b0;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          state_s = ST_IDLE;
          if (rx_data == CODE_LEFT_ARROW) begin
            arrow_left_s = 1'b0;
          end else if (rx_data == CODE_RIGHT_ARROW) begin
            arrow_right_s = 1'b0;
          end else begin
            arrow_left_s = arrow_left_r;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else if (timeout_s) begin
      // abandon the sequence; held keys stay as they were
      state_s     = ST_IDLE;
      seq_error_s = 1'b1;
    end else begin
      state_s = state_r;
    end
  end

  // Direction resolution from the registered held flags.
  always_comb begin
    left_held_s  = arrow_left_r | alt_left_r;
    right_held_s = arrow_right_r | alt_right_r;
    m_left_s     = left_held_s & (~right_held_s | (last_dir_r == DIR_LEFT));
    m_right_s    = right_held_s & (~left_held_s | (last_dir_r == DIR_RIGHT));
  end

  // Decoder state, timeout counter and held-key flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      arrow_left_r  <= 1'b0;
      arrow_right_r <= 1'b0;
      alt_left_r    <= 1'b0;
      alt_right_r   <= 1'b0;
      action_r      <= 1'b0;
      last_dir_r    <= DIR_LEFT;
      seq_error_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      arrow_left_r  <= arrow_left_s;
      arrow_right_r <= arrow_right_s;
      alt_left_r    <= alt_left_s;
      alt_right_r   <= alt_right_s;
      action_r      <= action_s;
      last_dir_r    <= last_dir_s;
      seq_error_r   <= seq_error_s;
    end
  end

  // Output register: one cycle behind the flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left_r     <= 1'b0;
      m_right_r    <= 1'b0;
      key_action_r <= 1'b0;
    end else begin
      m_left_r     <= m_left_s;
      m_right_r    <= m_right_s;
      key_action_r <= action_r;
    end
  end

  assign m_left     = m_left_r;
  assign m_right    = m_right_r;
  assign key_action = key_action_r;
  assign seq_error  = seq_error_r;

endmodule

// File: tb/tb_keyboard_move_ctl.sv
// Bench for keyboard_move_ctl: hand-derived vector table, hand-written
// timeout and reset sequences, then randomized bytes against a reference model.
module tb_keyboard_move_ctl;

  localparam int PT = 16;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       m_left, m_right, key_action, seq_error;

  int errors = 0;
  int checks = 0;

  keyboard_move_ctl #(.PREFIX_TIMEOUT(PT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .m_left     (m_left),
    .m_right    (m_right),
    .key_action (key_action),
    .seq_error  (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pending prefix bytes, key set and last pressed direction.
  bit pend_ext, pend_brk;
  int quiet_edges;
  bit held_al, held_ar, held_kl, held_kr, held_act; // arrow l/r, alt (key) l/r, action
  bit last_was_right;
  logic [3:0] exp_out; // {m_left, m_right, key_action, seq_error}

  task automatic model_reset();
    pend_ext = 0; pend_brk = 0; quiet_edges = 0;
    held_al = 0; held_ar = 0; held_kl = 0; held_kr = 0; held_act = 0;
    last_was_right = 0;
    exp_out = 4'b0000;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    bit lh, rh;
    lh = held_al | held_kl;
    rh = held_ar | held_kr;
    // outputs lag the key set by one clock; error pulse does not
    exp_out[3] = lh && (!rh || !last_was_right);
    exp_out[2] = rh && (!lh || last_was_right);
    exp_out[1] = held_act;
    exp_out[0] = 1'b0;
    if (v) begin
      quiet_edges = 0;
      if (!pend_ext && !pend_brk) begin
        if (d == 8'hE0) pend_ext = 1;
        else if (d == 8'hF0) pend_brk = 1;
        else if (d == 8'h1C) begin held_kl = 1; last_was_right = 0; end
        else if (d == 8'h23) begin held_kr = 1; last_was_right = 1; end
        else if (d == 8'h29) held_act = 1;
      end else if (pend_ext && !pend_brk) begin
        if (d == 8'hF0) pend_brk = 1;
        else if (d == 8'hE0) pend_ext = 1;
        else begin
          if (d == 8'h6B) begin held_al = 1; last_was_right = 0; end
          if (d == 8'h74) begin held_ar = 1; last_was_right = 1; end
          pend_ext = 0;
        end
      end else if (!pend_ext && pend_brk) begin
        if (d != 8'hF0) begin
          if (d == 8'h1C) held_kl = 0;
          if (d == 8'h23) held_kr = 0;
          if (d == 8'h29) held_act = 0;
          pend_brk = 0;
        end
      end else begin
        if (d == 8'h6B) held_al = 0;
        if (d == 8'h74) held_ar = 0;
        pend_ext = 0; pend_brk = 0;
      end
    end else if (pend_ext || pend_brk) begin
      quiet_edges++;
      if (quiet_edges == PT) begin
        pend_ext = 0; pend_brk = 0; quiet_edges = 0;
        exp_out[0] = 1'b1;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual={ml,mr,act,err}=%b expected=%b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {m_left, m_right, key_action, seq_error};
  endfunction

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [3:0] e);
    vec_t r;
    r.v = v; r.d = d; r.exp = e;
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int first_err;
    int pulses;
    byte unsigned pool[9];

    // right arrow make then break
    tbl.push_back(mk(1'b1, 8'hE0, 4'b0000));
    tbl.push_back(mk(1'b1, 8'h74, 4'b0000));
    tbl.push_back(mk(1'b0, 8'h00, 4'b0100));
    tbl.push_back(mk(1'b1, 8'hE0, 4'b0100));
    tbl.push_back(mk(1'b1, 8'hF0, 4'b0100));
    tbl.push_back(mk(1'b1, 8'h74, 4'b0100));
    tbl.push_back(mk(1'b0, 8'h00, 4'b0000));
    // A held, right arrow pressed later wins, released -> A shows again
    tbl.push_back(mk(1'b1, 8'h1C, 4'b0000));
    tbl.push_back(mk(1'b1, 8'hE0, 4'b1000));
    tbl.push_back(mk(1'b1, 8'h74, 4'b1000));
    tbl.push_back(mk(1'b0, 8'h00, 4'b0100));
    tbl.push_back(mk(1'b1, 8'hE0, 4'b0100));
    tbl.push_back(mk(1'b1, 8'hF0, 4'b0100));
    tbl.push_back(mk(1'b1, 8'h74, 4'b0100));
    tbl.push_back(mk(1'b0, 8'h00, 4'b1000));
    tbl.push_back(mk(1'b1, 8'hF0, 4'b1000));
    tbl.push_back(mk(1'b1, 8'h1C, 4'b1000));
    tbl.push_back(mk(1'b0, 8'h00, 4'b0000));
    // left arrow with typematic repeats, then break of A which is not held
    tbl.push_back(mk(1'b1, 8'hE0, 4'b0000));
    tbl.push_back(mk(1'b1, 8'h6B, 4'b0000));
    tbl.push_back(mk(1'b0, 8'h00, 4'b1000));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(1'b1, 8'hE0, 4'b1000));
      tbl.push_back(mk(1'b1, 8'h6B, 4'b1000));
    end
    tbl.push_back(mk(1'b1, 8'hF0, 4'b1000));
    tbl.push_back(mk(1'b1, 8'h1C, 4'b1000));
    tbl.push_back(mk(1'b0, 8'h00, 4'b1000));
    tbl.push_back(mk(1'b1, 8'hE0, 4'b1000));
    tbl.push_back(mk(1'b1, 8'hF0, 4'b1000));
    tbl.push_back(mk(1'b1, 8'h6B, 4'b1000));
    tbl.push_back(mk(1'b0, 8'h00, 4'b0000));
    // unknown bytes in IDLE
    tbl.push_back(mk(1'b1, 8'hAA, 4'b0000));
    tbl.push_back(mk(1'b1, 8'hFA, 4'b0000));
    tbl.push_back(mk(1'b1, 8'hE1, 4'b0000));
    tbl.push_back(mk(1'b1, 8'h14, 4'b0000));
    tbl.push_back(mk(1'b0, 8'h00, 4'b0000));
    // action key make/break
    tbl.push_back(mk(1'b1, 8'h29, 4'b0000));
    tbl.push_back(mk(1'b0, 8'h00, 4'b0010));
    tbl.push_back(mk(1'b1, 8'hF0, 4'b0010));
    tbl.push_back(mk(1'b1, 8'h29, 4'b0010));
    tbl.push_back(mk(1'b0, 8'h00, 4'b0000));

    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C, 8'h23, 8'h29, 8'hAA, 8'h14};

    // reset
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), 4'b0000);
    rst = 1'b0;

    // table
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // prefix timeout: E0 then silence
    step(1'b1, 8'hE0);
    first_err = -1;
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 8'h00);
      if (seq_error === 1'b1) begin
        pulses++;
        if (first_err < 0) first_err = i;
      end
    end
    checks++;
    if (first_err != PT) begin
      errors++;
      $display("FAIL timeout_cycle actual=%0d expected=%0d", first_err, PT);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL timeout_pulses actual=%0d expected=1", pulses);
    end
    step(1'b1, 8'h74);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("after_timeout_74", outs(), 4'b0000);

    // async reset in the middle of E0 F0 while action held
    step(1'b1, 8'h29);
    step(1'b0, 8'h00);
    check("action_held", outs(), 4'b0010);
    step(1'b1, 8'hE0);
    step(1'b1, 8'hF0);
    #2 rst = 1'b1;
    #1;
    check("async_reset", outs(), 4'b0000);
    model_reset();
    #3 rst = 1'b0;
    step(1'b1, 8'h6B);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("bare_6B_after_reset", outs(), 4'b0000);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ((i % 150) == 149) begin
        for (int j = 0; j < 20; j++) begin
          step(1'b0, 8'h00);
          check($sformatf("rand_gap%0d_%0d", i, j), outs(), exp_out);
        end
      end else if ($urandom_range(0, 99) < 45) begin
        step(1'b1, pool[$urandom_range(0, 8)]);
        check($sformatf("rand%0d", i), outs(), exp_out);
      end else begin
        step(1'b0, 8'h00);
        check($sformatf("rand%0d", i), outs(), exp_out);
      end
      checks++;
      if (m_left === 1'b1 && m_right === 1'b1) begin
        errors++;
        $display("FAIL exclusive%0d actual=both_set expected=at_most_one", i);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
